toast_acc_dispatch: RTL and testbench
=====================================

TOAST_ACC_DISPATCH -- requirements
Module: toast_acc_dispatch

Interface
REQ-001 Parameters SHALL be: REG_DATA_WIDTH, default 32, width of operand and immediate fields.
REQ-002 Parameter FIFO_DEPTH SHALL be: default 4, number of command-queue entries, power of two.
REQ-003 Parameter MAX_OUT SHALL be: default 4, maximum commands issued to the accelerator and not yet completed.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be as follows; each line gives name, direction, width and meaning.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard the command presented this cycle.
- ID_en_i  in  1  accelerator command present from the decode stage.
- ID_command_i  in  3  command code; 3'b111 = SYNC.
- ID_rm1_data_i  in  REG_DATA_WIDTH  operand 1.
- ID_rm2_data_i  in  REG_DATA_WIDTH  operand 2.
- ID_imm4_i  in  REG_DATA_WIDTH  immediate.
- stall_o  out  1  pipeline stall request.
- acc_valid_o  out  1  head command is offered to the accelerator.
- acc_ready_i  in  1  accelerator accepts the offered command.
- acc_command_o  out  3  head command code.
- acc_op1_o  out  REG_DATA_WIDTH  head operand 1.
- acc_op2_o  out  REG_DATA_WIDTH  head operand 2.
- acc_imm_o  out  REG_DATA_WIDTH  head immediate.
- acc_done_i  in  1  one-cycle pulse; one issued command has completed.
- busy_o  out  1  queue is non-empty or commands are outstanding.
- err_o  out  1  sticky protocol error.

Function
REQ-006 The block SHALL hold a circular FIFO of FIFO_DEPTH entries {command, op1, op2, imm}, with wrapping read and write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-007 Enqueue SHALL occur when ID_en_i=1, flush_i=0 and count<FIFO_DEPTH; the entry SHALL be written at the clock edge.
REQ-008 stall_o SHALL equal ID_en_i & ~flush_i & (count==FIFO_DEPTH), combinationally; a dequeue in the same cycle SHALL NOT lift the stall.
REQ-009 When flush_i=1, the incoming command SHALL be dropped and entries already queued SHALL be unaffected.
REQ-010 The FSM SHALL have exactly two states: RUN and DRAIN.
REQ-011 In RUN, acc_valid_o SHALL be 1 when the FIFO is non-empty, the head is not SYNC and outstanding<MAX_OUT; otherwise acc_valid_o SHALL be 0.
REQ-012 acc_command_o, acc_op1_o, acc_op2_o and acc_imm_o SHALL always reflect the FIFO head, and SHALL be held stable while acc_valid_o=1 and acc_ready_i=0.
REQ-013 Dequeue-issue SHALL occur on acc_valid_o & acc_ready_i; this pops the head and increments the outstanding counter.
REQ-014 Latency: a command enqueued at edge N into an empty FIFO SHALL assert acc_valid_o in cycle N+1.
REQ-015 In RUN, a SYNC at the head SHALL cause a transition to DRAIN; SYNC SHALL never be offered on acc_valid_o.
REQ-016 DRAIN SHALL pop the SYNC without issuing it and return to RUN when outstanding==0, evaluated after this cycle's acc_done_i.
REQ-017 In DRAIN, acc_valid_o SHALL be 0.
REQ-018 Outstanding counter, width clog2(MAX_OUT)+1: issue without done SHALL give +1; done without issue SHALL give -1; issue and done in the same cycle SHALL leave it unchanged.
REQ-019 acc_done_i with outstanding==0 and no issue in the same cycle SHALL leave the counter at 0 and set err_o.
REQ-020 err_o SHALL stay set until reset.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged, and both pointers SHALL advance.
REQ-022 busy_o SHALL equal (count!=0) | (outstanding!=0) | (state==DRAIN).

Reset
REQ-023 When reset_i=1 at an edge, the block SHALL set the pointers, count and outstanding to 0, the state to RUN and err_o to 0.
REQ-024 During reset, acc_valid_o, stall_o and busy_o SHALL be 0 in the cycle following the reset edge; the payload outputs are don't-care while empty.
REQ-025 Reset mid-operation SHALL discard queued entries and outstanding tracking, with no issue in the cycle after reset.

Verification
REQ-026 Single command: ID_en_i=1, cmd=3'b010, op1=0x11, op2=0x22, imm=0x33 at edge 0, acc_ready_i=1 -> acc_valid_o=1 in cycle 1 with those values; busy_o stays 1 until acc_done_i.
REQ-027 Full FIFO: acc_ready_i=0, 5 back-to-back commands -> 4 are queued and stall_o=1 on the 5th; acc_ready_i=1 -> the 5th is enqueued on the cycle after the stall clears, in FIFO order.
REQ-028 MAX_OUT limit: 6 commands, acc_ready_i=1, no done -> exactly 4 are issued and acc_valid_o drops to 0; one acc_done_i pulse -> a 5th is issued on the next cycle.
REQ-029 SYNC: sequence cmd1, SYNC, cmd2 with cmd1 issued and not done -> cmd2 is not offered; acc_done_i -> DRAIN exits and cmd2 is offered 1 cycle after the SYNC pop.
REQ-030 Flush and error: ID_en_i=1 with flush_i=1 -> no enqueue and busy_o=0; acc_done_i with outstanding 0 -> err_o=1 until reset_i.
REQ-031 Reset mid-stream: 3 commands queued and 2 outstanding, reset_i pulsed -> acc_valid_o=0, busy_o=0, err_o=0 in the next cycle.

Source files
------------

// File: rtl/toast_acc_dispatch.sv
// In-order accelerator command dispatcher: a small command queue fed by decode,
// issued to the accelerator under an outstanding-command limit, with SYNC barriers.
module toast_acc_dispatch #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_OUT        = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      ID_en_i,
    input  logic [2:0]                ID_command_i,
    input  logic [REG_DATA_WIDTH-1:0] ID_rm1_data_i,
    input  logic [REG_DATA_WIDTH-1:0] ID_rm2_data_i,
    input  logic [REG_DATA_WIDTH-1:0] ID_imm4_i,
    output logic                      stall_o,
    output logic                      acc_valid_o,
    input  logic                      acc_ready_i,
    output logic [2:0]                acc_command_o,
    output logic [REG_DATA_WIDTH-1:0] acc_op1_o,
    output logic [REG_DATA_WIDTH-1:0] acc_op2_o,
    output logic [REG_DATA_WIDTH-1:0] acc_imm_o,
    input  logic                      acc_done_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [2:0]       CMD_SYNC  = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [2:0]                cmd_mem_r [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0] op1_mem_r [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0] op2_mem_r [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0] imm_mem_r [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [OUT_W-1:0] out_r;
    state_t           state_r;
    logic             err_r;

    logic             empty_s;
    logic             full_s;
    logic             head_sync_s;
    logic             enq_s;
    logic             valid_s;
    logic             issue_s;
    logic             drain_pop_s;
    logic             deq_s;
    logic             err_set_s;
    logic [OUT_W-1:0] out_next_s;

    // Queue handshakes, outstanding-count update and barrier release.
    always_comb begin
        empty_s     = (count_r == {CNT_W{1'b0}});
        full_s      = (count_r == DEPTH_C);
        head_sync_s = (cmd_mem_r[rd_ptr_r] == CMD_SYNC);
        enq_s       = ID_en_i & ~flush_i & ~full_s;
        valid_s     = (state_r == ST_RUN) & ~empty_s & ~head_sync_s & (out_r < MAX_OUT_C);
        issue_s     = valid_s & acc_ready_i;
        out_next_s  = out_r;
        err_set_s   = 1'b0;
        if (issue_s & ~acc_done_i) begin
            out_next_s = out_r + OUT_W'(1);
        end else if (~issue_s & acc_done_i) begin
            if (out_r == {OUT_W{1'b0}}) begin
                err_set_s = 1'b1;
            end else begin
                out_next_s = out_r - OUT_W'(1);
            end
        end else begin
            out_next_s = out_r;
        end
        // The barrier is released once the completion seen this cycle retires the last command.
        drain_pop_s = (state_r == ST_DRAIN) & (out_next_s == {OUT_W{1'b0}});
        deq_s       = issue_s | drain_pop_s;
    end

    // Output drive; payload always mirrors the queue head.
    always_comb begin
        stall_o       = ID_en_i & ~flush_i & full_s;
        acc_valid_o   = valid_s;
        acc_command_o = cmd_mem_r[rd_ptr_r];
        acc_op1_o     = op1_mem_r[rd_ptr_r];
        acc_op2_o     = op2_mem_r[rd_ptr_r];
        acc_imm_o     = imm_mem_r[rd_ptr_r];
        busy_o        = ~empty_s | (out_r != {OUT_W{1'b0}}) | (state_r == ST_DRAIN);
        err_o         = err_r;
    end

    // Queue storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            cmd_mem_r[wr_ptr_r] <= ID_command_i;
            op1_mem_r[wr_ptr_r] <= ID_rm1_data_i;
            op2_mem_r[wr_ptr_r] <= ID_rm2_data_i;
            imm_mem_r[wr_ptr_r] <= ID_imm4_i;
        end
    end

    // Pointers, occupancy, outstanding tracking and sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            out_r    <= {OUT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            out_r <= out_next_s;
            err_r <= err_r | err_set_s;
        end
    end

    // RUN/DRAIN sequencing around SYNC barriers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (~empty_s & head_sync_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_pop_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_toast_acc_dispatch.sv
// Bench for toast_acc_dispatch: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_toast_acc_dispatch;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 4;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         en;
    logic [2:0]   cmd;
    logic [W-1:0] rm1;
    logic [W-1:0] rm2;
    logic [W-1:0] imm4;
    logic         stall;
    logic         valid;
    logic         ready;
    logic [2:0]   a_cmd;
    logic [W-1:0] a_op1;
    logic [W-1:0] a_op2;
    logic [W-1:0] a_imm;
    logic         done;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]   cmd;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [W-1:0] imm;
    } ent_t;

    ent_t mq[$];
    int   m_out   = 0;
    bit   m_drain = 1'b0;
    bit   m_err   = 1'b0;

    toast_acc_dispatch #(.REG_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .ID_en_i(en),
        .ID_command_i(cmd), .ID_rm1_data_i(rm1), .ID_rm2_data_i(rm2), .ID_imm4_i(imm4),
        .stall_o(stall), .acc_valid_o(valid), .acc_ready_i(ready),
        .acc_command_o(a_cmd), .acc_op1_o(a_op1), .acc_op2_o(a_op2), .acc_imm_o(a_imm),
        .acc_done_i(done), .busy_o(busy), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_valid();
        return !m_drain && (mq.size() > 0) && (mq[0].cmd != 3'b111) && (m_out < MAXO);
    endfunction

    // Advance one clock edge with the current inputs, updating the reference model.
    task automatic tick();
        bit   iss;
        bit   enq;
        int   sz;
        ent_t e;
        sz  = mq.size();
        iss = m_valid() && (ready == 1'b1);
        enq = (en == 1'b1) && (flush == 1'b0) && (sz < DEPTH);
        e.cmd = cmd; e.op1 = rm1; e.op2 = rm2; e.imm = imm4;
        if (reset) begin
            mq.delete(); m_out = 0; m_drain = 1'b0; m_err = 1'b0;
        end else begin
            if (m_drain) begin
                if (done) begin
                    if (m_out == 0) m_err = 1'b1; else m_out--;
                end
                if (m_out == 0) begin
                    void'(mq.pop_front());
                    m_drain = 1'b0;
                end
            end else begin
                if (iss && !done) m_out++;
                else if (!iss && done) begin
                    if (m_out == 0) m_err = 1'b1; else m_out--;
                end
                if (iss) void'(mq.pop_front());
                else if (sz > 0 && mq[0].cmd == 3'b111) m_drain = 1'b1;
            end
            if (enq) mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        en = 1'b0; flush = 1'b0; done = 1'b0; cmd = 3'b000;
        rm1 = '0; rm2 = '0; imm4 = '0;
    endtask

    task automatic drive_cmd(input logic [2:0] c);
        en = 1'b1; cmd = c; rm1 = $urandom; rm2 = $urandom; imm4 = $urandom;
    endtask

    // Retire everything still queued or outstanding, with a bounded cycle budget.
    task automatic drain_all();
        int n = 0;
        set_idle();
        ready = 1'b1;
        while ((mq.size() > 0 || m_out > 0 || m_drain) && n < 40) begin
            done = (m_out > 0) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        set_idle();
        #1;
        checks++;
        if (busy !== 1'b0 || n >= 40) begin
            errors++;
            $display("FAIL drain_idle: busy=%0b cycles=%0d, required busy=0 within 40", busy, n);
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1; ready = 1'b1;
        drive_cmd(3'b011);
        tick();
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", valid); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b required 0", stall); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", err); end
        reset = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic test_single();
        set_idle();
        ready = 1'b1;
        en = 1'b1; cmd = 3'b010; rm1 = 32'h11; rm2 = 32'h22; imm4 = 32'h33;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %0b required 0", valid); end
        tick();
        set_idle();
        #1;
        checks++;
        if ({valid, a_cmd} !== {1'b1, 3'b010}) begin
            errors++; $display("FAIL single_issue: valid/cmd got %0b/%0h required 1/2", valid, a_cmd);
        end
        checks++;
        if ({a_op1, a_op2, a_imm} !== {32'h11, 32'h22, 32'h33}) begin
            errors++; $display("FAIL single_payload: got %0h %0h %0h required 11 22 33", a_op1, a_op2, a_imm);
        end
        tick();
        checks++;
        if ({valid, busy} !== 2'b01) begin
            errors++; $display("FAIL single_outstanding: valid/busy got %0b/%0b required 0/1", valid, busy);
        end
        done = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done: got %0b required 1", busy); end
        tick();
        done = 1'b0;
        #1;
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++; $display("FAIL single_retired: busy/err got %0b/%0b required 0/0", busy, err);
        end
    endtask

    task automatic test_full();
        set_idle();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(3'(i));
            #1;
            checks++;
            if (stall !== (i == 4)) begin
                errors++; $display("FAIL full_stall_%0d: got %0b required %0b", i, stall, (i == 4));
            end
            if (i < 4) tick();
        end
        ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_deq: got %0b required 1", stall); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({valid, a_cmd} !== {1'b1, 3'(i)}) begin
                errors++; $display("FAIL full_order_%0d: valid/cmd got %0b/%0h required 1/%0h", i, valid, a_cmd, i);
            end
            if (i == 1) begin
                checks++;
                if (stall !== 1'b0) begin errors++; $display("FAIL full_stall_clear: got %0b required 0", stall); end
            end
            tick();
            if (i >= 1) en = 1'b0;
            done = 1'b1;
            #1;
        end
        drain_all();
    endtask

    task automatic test_maxout();
        int n_iss = 0;
        set_idle();
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive_cmd(3'(c + 1)); else en = 1'b0;
            #1;
            if (valid === 1'b1) n_iss++;
            tick();
        end
        #1;
        checks++;
        if (n_iss !== 4) begin errors++; $display("FAIL maxout_count: got %0d required 4", n_iss); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL maxout_hold: got %0b required 0", valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        checks++;
        if ({valid, a_cmd} !== {1'b1, 3'd5}) begin
            errors++; $display("FAIL maxout_fifth: valid/cmd got %0b/%0h required 1/5", valid, a_cmd);
        end
        drain_all();
    endtask

    task automatic test_sync();
        set_idle();
        ready = 1'b1;
        drive_cmd(3'b001); tick();
        drive_cmd(3'b111);
        #1;
        checks++;
        if ({valid, a_cmd} !== {1'b1, 3'b001}) begin
            errors++; $display("FAIL sync_cmd1: valid/cmd got %0b/%0h required 1/1", valid, a_cmd);
        end
        tick();
        drive_cmd(3'b010);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({valid, busy} !== 2'b01) begin
                errors++; $display("FAIL sync_blocked_%0d: valid/busy got %0b/%0b required 0/1", c, valid, busy);
            end
            tick();
            en = 1'b0;
        end
        done = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL sync_done_cycle: got %0b required 0", valid); end
        tick();
        done = 1'b0;
        #1;
        checks++;
        if ({valid, a_cmd} !== {1'b1, 3'b010}) begin
            errors++; $display("FAIL sync_release: valid/cmd got %0b/%0h required 1/2", valid, a_cmd);
        end
        drain_all();
    endtask

    task automatic test_flush_err();
        set_idle();
        ready = 1'b1;
        drive_cmd(3'b011);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b required 0", stall); end
        tick();
        set_idle();
        #1;
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++; $display("FAIL flush_drop: busy/valid got %0b/%0b required 0/0", busy, valid);
        end
        done = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %0b required 0", err); end
        tick();
        done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_%0d: got %0b required 1", c, err); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) ready = 1'b0;
            drive_cmd(3'(c));
            tick();
        end
        set_idle();
        #1;
        checks++;
        if ({busy, err} !== 2'b11) begin
            errors++; $display("FAIL mid_pre_reset: busy/err got %0b/%0b required 1/1", busy, err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready = 1'b1;
        #1;
        checks++;
        if ({valid, busy, err} !== 3'b000) begin
            errors++; $display("FAIL mid_reset: valid/busy/err got %0b/%0b/%0b required 0/0/0", valid, busy, err);
        end
        tick();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++; $display("FAIL mid_post: valid/busy got %0b/%0b required 0/0", valid, busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(299) == 0);
            if ($urandom_range(1) == 1) drive_cmd(3'($urandom_range(7))); else en = 1'b0;
            flush = ($urandom_range(9) == 0);
            ready = ($urandom_range(9) < 6);
            if (m_out > 0) done = ($urandom_range(99) < 35);
            else           done = ($urandom_range(399) == 0);
            #1;
            checks++;
            if (valid !== m_valid()) begin
                errors++; $display("FAIL rnd_valid c%0d: got %0b required %0b", c, valid, m_valid());
            end
            checks++;
            if (stall !== (en && !flush && mq.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_stall c%0d: got %0b required %0b", c, stall, (en && !flush && mq.size() == DEPTH));
            end
            checks++;
            if (busy !== (mq.size() > 0 || m_out > 0 || m_drain)) begin
                errors++; $display("FAIL rnd_busy c%0d: got %0b required %0b", c, busy, (mq.size() > 0 || m_out > 0 || m_drain));
            end
            checks++;
            if (err !== m_err) begin
                errors++; $display("FAIL rnd_err c%0d: got %0b required %0b", c, err, m_err);
            end
            if (m_valid()) begin
                checks++;
                if ({a_cmd, a_op1, a_op2, a_imm} !== mq[0]) begin
                    errors++; $display("FAIL rnd_payload c%0d: got %0h %0h %0h %0h required %0h %0h %0h %0h",
                                       c, a_cmd, a_op1, a_op2, a_imm, mq[0].cmd, mq[0].op1, mq[0].op2, mq[0].imm);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        set_idle();
        test_reset();
        test_single();
        test_full();
        test_maxout();
        test_sync();
        test_flush_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
